// File: rtl/spi_gdu_sequencer.sv
// spi_gdu_sequencer: parses framed SPI byte commands into a FIFO and issues them to the GDU as DRA/KZS/KZC strobes.
module spi_gdu_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic        clk_24m,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [7:0]  i_result,
  input  logic [1:0]  i_dev_ZT,
  input  logic        i_dev_ZDQQ,
  output logic [15:0] o_dev_SR,
  output logic        o_DRA,
  output logic        o_KZS,
  output logic        o_KZC,
  output logic        o_busy,
  output logic        o_err_ovf,
  output logic        o_err_frame
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [1:0] T_WR = 2'd0, T_START = 2'd1, T_CLEAR = 2'd2;
  typedef enum logic [2:0] {P_HUNT, P_OPC, P_CNT, P_DHI, P_DLO} pstate_t;
  typedef enum logic [1:0] {I_IDLE, I_EXEC, I_GAP, I_WAIT} istate_t;
  pstate_t r_ps, w_ps_nx;
  istate_t r_is, w_is_nx;
  logic [TW-1:0] r_to;
  logic [7:0]    r_rem, r_hi;
  logic [17:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [GW-1:0] r_gap;
  logic [1:0]    r_cur_t;
  logic [15:0]   r_sr;
  logic          r_err_ovf, r_err_frame;
  logic          w_push, w_frame_err, w_clr_err, w_timeout, w_full, w_empty, w_wr, w_pop, w_gap_done, w_exec;
  logic [17:0]   w_push_d, w_head;
  assign w_timeout  = r_ps != P_HUNT && !i_valid && r_to == TW'(TIMEOUT_CYC);
  assign w_full     = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_head     = r_mem[r_rp];
  assign w_gap_done = r_gap == GW'(GAP_CYC - 1);
  // The last GAP cycle doubles as IDLE so back-to-back strobes land GAP_CYC+1 cycles apart.
  assign w_pop = !w_empty && i_dev_ZT == 2'b00 &&
                 (r_is == I_IDLE || (r_is == I_GAP && w_gap_done && r_cur_t != T_START));
  assign w_wr  = w_push && (!w_full || w_pop);
  always_comb begin
    w_ps_nx     = r_ps;
    w_push      = 1'b0;
    w_push_d    = '0;
    w_frame_err = 1'b0;
    w_clr_err   = 1'b0;
    if (i_valid) begin
      case (r_ps)
        P_HUNT: w_ps_nx = i_result == 8'hA5 ? P_OPC : P_HUNT;
        P_OPC: begin
          w_ps_nx     = i_result == 8'h01 ? P_CNT : P_HUNT;
          w_push      = i_result == 8'h02 || i_result == 8'h03;
          w_push_d    = {i_result == 8'h02 ? T_START : T_CLEAR, 16'h0};
          w_clr_err   = i_result == 8'h04;
          w_frame_err = i_result == 8'h00 || i_result > 8'h04;
        end
        P_CNT: w_ps_nx = i_result == 8'h00 ? P_HUNT : P_DHI;
        P_DHI: w_ps_nx = P_DLO;
        default: begin
          w_ps_nx  = r_rem == 8'd1 ? P_HUNT : P_DHI;
          w_push   = 1'b1;
          w_push_d = {T_WR, r_hi, i_result};
        end
      endcase
    end else if (w_timeout) begin
      w_ps_nx     = P_HUNT;
      w_frame_err = 1'b1;
    end
  end
  always_comb begin
    w_is_nx = r_is == I_EXEC ? I_GAP :
              w_pop ? I_EXEC :
              r_is == I_WAIT ? (i_dev_ZDQQ ? I_IDLE : I_WAIT) :
              r_is == I_GAP ? (!w_gap_done ? I_GAP : r_cur_t == T_START ? I_WAIT : I_IDLE) :
              I_IDLE;
  end
  always_ff @(posedge clk_24m) if (w_wr) r_mem[r_wp] <= w_push_d;
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      r_ps        <= P_HUNT;
      r_is        <= I_IDLE;
      r_to        <= '0;
      r_rem       <= '0;
      r_hi        <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_cur_t     <= T_WR;
      r_sr        <= '0;
      r_err_ovf   <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_ps        <= w_ps_nx;
      r_is        <= w_is_nx;
      r_to        <= (r_ps == P_HUNT || i_valid) ? '0 : r_to + 1'b1;
      r_rem       <= (i_valid && r_ps == P_CNT) ? i_result : (i_valid && r_ps == P_DLO) ? r_rem - 1'b1 : r_rem;
      r_hi        <= (i_valid && r_ps == P_DHI) ? i_result : r_hi;
      r_wp        <= w_wr ? r_wp + 1'b1 : r_wp;
      r_rp        <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt       <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_gap       <= r_is == I_GAP ? r_gap + 1'b1 : '0;
      r_cur_t     <= w_pop ? w_head[17:16] : r_cur_t;
      r_sr        <= (w_pop && w_head[17:16] == T_WR) ? w_head[15:0] : r_sr;
      r_err_ovf   <= (w_push && w_full && !w_pop) ? 1'b1 : w_clr_err ? 1'b0 : r_err_ovf;
      r_err_frame <= w_frame_err ? 1'b1 : w_clr_err ? 1'b0 : r_err_frame;
    end
  end
  assign w_exec      = r_is == I_EXEC && !rst;
  assign o_DRA       = w_exec && r_cur_t == T_WR;
  assign o_KZS       = w_exec && r_cur_t == T_START;
  assign o_KZC       = w_exec && r_cur_t == T_CLEAR;
  assign o_dev_SR    = r_sr;
  assign o_busy      = !w_empty || r_is != I_IDLE;
  assign o_err_ovf   = r_err_ovf;
  assign o_err_frame = r_err_frame;
endmodule

// File: doc/spi_gdu_sequencer.md
Name: spi_gdu_sequencer

Overview:
- Command sequencer between the SPI byte receiver and the DJS130 graphics display unit (GDU) device interface.
- Parses framed byte commands from the receiver's valid/result stream and queues them in a small FIFO.
- Issues queued commands to the GDU one at a time as data-ready (DRA), start (KZS) and clear (KZC) strobes, with o_dev_SR data.
- Paces issue on GDU busy status (ZT) and on the completion interrupt (ZDQQ).

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- GAP_CYC, 8, idle cycles after every strobe before the next issue; minimum 1.
- TIMEOUT_CYC, 24000, maximum clk_24m cycles between bytes inside a frame (1 ms).

Ports:
- clk_24m  in  1  system clock, 24 MHz.
- rst  in  1  synchronous reset, active-high.
- i_valid  in  1  single-cycle byte strobe from SPI receiver, already in the clk_24m domain.
- i_result  in  8  received byte; qualified by i_valid.
- i_dev_ZT  in  2  GDU status; 2'b00 = idle, any other value = busy.
- i_dev_ZDQQ  in  1  GDU completion interrupt, level.
- o_dev_SR  out  16  data word to GDU; held between writes.
- o_DRA  out  1  one-cycle data-ready strobe.
- o_KZS  out  1  one-cycle start strobe.
- o_KZC  out  1  one-cycle clear strobe.
- o_busy  out  1  FIFO non-empty or issuer not in IDLE.
- o_err_ovf  out  1  sticky: a command was dropped because the FIFO was full.
- o_err_frame  out  1  sticky: bad opcode or intra-frame timeout.

Behaviour:
- Reset: all outputs 0, FIFO empty, parser in HUNT, issuer in IDLE, counters 0. Reset mid-frame or mid-issue abandons the work; no strobe is emitted in the reset cycle or the cycle after.
- Frame format: 0xA5, opcode, then operands per opcode.
  - 0x01: count N, then N words, high byte first.
  - 0x02: START.
  - 0x03: CLEAR.
  - 0x04: clear both error flags.
- Parser FSM, advancing only on i_valid:
  - HUNT: 0xA5 -> OPC; any other byte is ignored.
  - OPC: 0x01 -> CNT; 0x02 -> push START, go HUNT; 0x03 -> push CLEAR, go HUNT; 0x04 -> clear both error flags, go HUNT; any other byte -> set o_err_frame, go HUNT.
  - CNT: load 8-bit remaining = byte; if byte = 0 -> HUNT, else -> DHI.
  - DHI: latch high byte -> DLO.
  - DLO: push WR{hi,lo}, decrement remaining; if remaining reaches 0 -> HUNT, else -> DHI.
- Frame timeout: in any state other than HUNT, a counter clears on each i_valid. When it reaches TIMEOUT_CYC, the parser goes to HUNT and sets o_err_frame; partial words are discarded.
- FIFO entry: {type[1:0], data[15:0]}; types are WR, START, CLEAR.
  - A push takes effect on the clock edge after the triggering i_valid cycle.
  - Push while full with no pop: entry dropped, o_err_ovf set; the parser continues.
  - Push and pop in the same cycle while full: both accepted, count unchanged.
- Issuer FSM:
  - IDLE: if the FIFO is non-empty and i_dev_ZT == 2'b00, pop the head -> EXEC.
  - EXEC (one cycle):
    - WR: o_dev_SR <= data and o_DRA = 1 in the same cycle.
    - START: o_KZS = 1.
    - CLEAR: o_KZC = 1.
    - Then -> GAP.
  - GAP: count GAP_CYC cycles. Then START -> WAIT_INT; otherwise -> IDLE.
  - WAIT_INT: stay until i_dev_ZDQQ = 1, then -> IDLE. ZDQQ asserted outside WAIT_INT is ignored.
- Latency: i_valid of the final byte at cycle t -> entry in FIFO at t+1 -> if the issuer is IDLE and ZT = 00, the strobe is asserted in cycle t+2.
- Strobes are mutually exclusive and never longer than one cycle. o_dev_SR changes only in a WR EXEC cycle.
- Error flags: set has priority over a same-cycle 0x04 clear. Flags are also cleared by rst.
- o_busy is combinational from FIFO count and issuer state.

Test Plan:
- Bytes A5 01 02 12 34 AB CD with ZT = 00 -> o_DRA pulses twice, o_dev_SR = 16'h1234 then 16'hABCD; first pulse 2 cycles after the byte 34; the two pulses are GAP_CYC+1 cycles apart; no error flags.
- Bytes A5 02 with ZDQQ held low 50 cycles, then high; a following A5 03 sent during the wait -> one o_KZS pulse; o_KZC appears only after ZDQQ rises and GAP completes; o_busy = 1 throughout.
- ZT = 2'b01 while 6 WR words arrive (FIFO_DEPTH = 4) -> no strobes; o_err_ovf = 1; after ZT = 00, exactly 4 o_DRA pulses carrying the first 4 words.
- Bytes A5 01 03 11 22, then silence for TIMEOUT_CYC -> one write of 16'h1122, o_err_frame = 1, parser in HUNT; next frame A5 03 -> o_KZC pulse.
- Bytes A5 7F -> o_err_frame = 1; then A5 04 -> both flags return to 0; stray bytes 00 FF before A5 are ignored.
- rst asserted mid-frame (after A5 01 02 12) and during GAP -> all outputs 0 the next cycle; a fresh frame after reset executes normally.
